// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and default width shared by the serial adder files
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: gate-level one-bit full adder
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c_out
);
  logic p, g, t;
  xor (p, x, y);
  xor (s, p, z);
  and (g, x, y);
  and (t, p, z);
  or  (c_out, g, t);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, busy_q, done_q, s, c_out;
  full_adder u_fa (.x(a_q[0]), .y(b_q[0]), .z(carry_q), .s(s), .c_out(c_out));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    sum_d = sum_q;
    cout_d = cout_q;
    if (state_q == RUN) begin
      acc_d = {s, acc_q[WIDTH-1:1]};
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      carry_d = c_out;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
        sum_d = {s, acc_q[WIDTH-1:1]};
        cout_d = c_out;
      end
    end else if (start) begin
      state_d = RUN;
      a_d = a;
      b_d = b;
      carry_d = cin;
      cnt_d = '0;
      acc_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      busy_q <= state_d == RUN;
      done_q <= state_d == DONE;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and exhaustive checks of serial_adder at WIDTH 8 and 4
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset, start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic reset4, start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [8:0] exp);
    int lat, bc;
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
    bc = int'(busy);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    chk({tag, " latency"}, lat, 8);
    chk({tag, " busy cycles"}, bc, 8);
    chk({tag, " result"}, {cout, sum}, exp);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " result hold"}, {cout, sum}, exp);
  endtask
  initial begin
    int pulses, lat;
    logic [7:0] cap;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    reset4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", {cout, sum}, 0);
    reset = 1'b0;
    @(negedge clk);
    run8("5a+3c", 8'h5A, 8'h3C, 1'b0, 9'h096);
    run8("ff+01", 8'hFF, 8'h01, 1'b0, 9'h100);
    run8("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h10;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; cap = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin pulses++; cap = sum; end
    end
    chk("ignored start pulses", pulses, 1);
    chk("ignored start sum", cap, 8'h03);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      chk("b2b done", done, (k % 9 == 8) ? 1 : 0);
      chk("b2b busy", busy, (k % 9 == 8) ? 0 : 1);
      if (done) chk("b2b sum", {cout, sum}, 9'h010);
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b end idle", busy, 0);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", {cout, sum}, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort no done", pulses, 0);
    run8("7f+01", 8'h7F, 8'h01, 1'b0, 9'h080);
    reset = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset beats start", busy, 0);
    reset4 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
      @(negedge clk);
      start4 = 1'b0; a4 = ~v[3:0]; b4 = ~v[7:4]; cin4 = ~v[8];
      lat = 0;
      while (!done4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("w4 latency", lat, 4);
      chk("w4 result", {cout4, sum4}, 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
